// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that streams operands LS-nibble first through one 4-bit adder.
// The carry is held between cycles; the result lands in output registers on the last step.

module four_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       carry_o
);
    logic [4:0] full;

    assign full    = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
    assign sum_o   = full[3:0];
    assign carry_o = full[4];
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready_o depends only on state, never on out_ready_i.
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [3:0]       add_sum;
    logic             add_carry;
    logic [WIDTH-1:0] res_next;

    four_adder u_four_adder (
        .a_i     (a_q[3:0]),
        .b_i     (b_q[3:0]),
        .cin_i   (carry_q),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    assign res_next = {add_sum, res_q[WIDTH-1:4]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    carry_d = cin_i;
                    res_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = res_next;
                carry_d = add_carry;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    // Bit 3 of the final nibble is the operand/result sign bit.
                    sum_d   = res_next;
                    cout_d  = add_carry;
                    ovf_d   = (a_q[3] == b_q[3]) && (add_sum[3] != a_q[3]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == RUN);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;
    assign state_o     = state_q;
endmodule
